// File: rtl/rgb_effect_sequencer.sv
// rgb_effect_sequencer: lighting effect controller for the two-lamp RGB PWM bank.
// It generates its own effect tick from the speed switches and runs a mode FSM
// with four modes: off, rainbow, breathe and blink. It drives registered duty
// values for both lamps and strobes duty_valid whenever those values are refreshed.
//
// Ports:
//   clk                    system clock
//   rst                    synchronous active-high reset
//   key_mode               1-cycle pulse: advance mode OFF->RAINBOW->BREATHE->BLINK->OFF
//   key_lamp               1-cycle pulse: cycle lamp enables 11->01->10->11
//   key_sync               1-cycle pulse: toggle sync (lamp 2 tracks lamp 1 or runs reversed)
//   sw[3:0]                speed select; one-hot picks DIV_F1..F4, anything else DIV_DEF
//   r1,g1,b1 / r2,g2,b2    registered 8-bit duty for lamp 1 / lamp 2
//   duty_valid             1-cycle strobe: duty outputs were refreshed this cycle
//   mode[1:0]              current mode (0 OFF, 1 RAINBOW, 2 BREATHE, 3 BLINK)
module rgb_effect_sequencer #(
  parameter int unsigned DIV_F1  = 12500,
  parameter int unsigned DIV_F2  = 25000,
  parameter int unsigned DIV_F3  = 100000,
  parameter int unsigned DIV_F4  = 200000,
  parameter int unsigned DIV_DEF = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_mode,
  input  logic       key_lamp,
  input  logic       key_sync,
  input  logic [3:0] sw,
  output logic [7:0] r1,
  output logic [7:0] g1,
  output logic [7:0] b1,
  output logic [7:0] r2,
  output logic [7:0] g2,
  output logic [7:0] b2,
  output logic       duty_valid,
  output logic [1:0] mode
);

  typedef enum logic [1:0] {StOff, StRainbow, StBreathe, StBlink} mode_e;

  mode_e       state_q, state_d;
  logic [17:0] div_cnt_q, div_cnt_d, limit_q, limit_d, sw_limit;
  logic [9:0]  wheel_q, wheel_d;
  logic [7:0]  lvl_q, lvl_d;
  logic        dir_up_q, dir_up_d;
  logic [6:0]  blink_cnt_q, blink_cnt_d;
  logic        blink_on_q, blink_on_d;
  logic [1:0]  lamp_en_q, lamp_en_d;
  logic        sync_q, sync_d;
  logic        first_q;
  logic        tick, upd;
  logic [23:0] fwd, rev, lamp1, lamp2, lamp1_q, lamp2_q;
  logic        duty_valid_q;

  // Colour wheel: p in 0..764 maps to a packed {r, g, b}; rev selects the mirrored wheel.
  function automatic logic [23:0] wheel_rgb(input logic [9:0] p, input logic rv);
    logic [7:0] r, g, b;
    if (p < 10'd255) begin
      r = 8'(10'd255 - p);
      g = rv ? 8'(p) : 8'd0;
      b = rv ? 8'd0 : 8'(p);
    end else if (p < 10'd510) begin
      r = 8'd0;
      g = rv ? 8'(10'd510 - p) : 8'(p - 10'd255);
      b = rv ? 8'(p - 10'd255) : 8'(10'd510 - p);
    end else begin
      r = 8'(p - 10'd510);
      g = rv ? 8'd0 : 8'(10'd765 - p);
      b = rv ? 8'(10'd765 - p) : 8'd0;
    end
    return {r, g, b};
  endfunction

  always_comb begin
    case (sw)
      4'b1000: sw_limit = 18'(DIV_F1);
      4'b0100: sw_limit = 18'(DIV_F2);
      4'b0010: sw_limit = 18'(DIV_F3);
      4'b0001: sw_limit = 18'(DIV_F4);
      default: sw_limit = 18'(DIV_DEF);
    endcase
  end

  assign tick = (div_cnt_q == limit_q);
  assign upd  = first_q | tick | key_mode | key_lamp | key_sync;

  // Next-state: tick generator, mode FSM and phase counters.
  always_comb begin
    state_d     = state_q;
    wheel_d     = wheel_q;
    lvl_d       = lvl_q;
    dir_up_d    = dir_up_q;
    blink_cnt_d = blink_cnt_q;
    blink_on_d  = blink_on_q;
    lamp_en_d   = lamp_en_q;
    sync_d      = sync_q;
    // The limit only reloads on tick so a speed change never cuts a period short.
    div_cnt_d   = tick ? 18'd0 : div_cnt_q + 18'd1;
    limit_d     = tick ? sw_limit : limit_q;

    if (key_mode) begin
      // A mode change restarts every phase and swallows a coincident tick.
      unique case (state_q)
        StOff:     state_d = StRainbow;
        StRainbow: state_d = StBreathe;
        StBreathe: state_d = StBlink;
        StBlink:   state_d = StOff;
      endcase
      wheel_d     = 10'd0;
      lvl_d       = 8'd0;
      dir_up_d    = 1'b1;
      blink_cnt_d = 7'd0;
      blink_on_d  = 1'b1;
    end else if (tick) begin
      unique case (state_q)
        StOff: ;
        StRainbow: wheel_d = (wheel_q == 10'd764) ? 10'd0 : wheel_q + 10'd1;
        StBreathe: begin
          if (dir_up_q) begin
            if (lvl_q == 8'd255) begin
              lvl_d    = 8'd254;
              dir_up_d = 1'b0;
            end else begin
              lvl_d = lvl_q + 8'd1;
            end
          end else begin
            if (lvl_q == 8'd0) begin
              lvl_d    = 8'd1;
              dir_up_d = 1'b1;
            end else begin
              lvl_d = lvl_q - 8'd1;
            end
          end
        end
        StBlink: begin
          blink_cnt_d = blink_cnt_q + 7'd1;
          if (blink_cnt_q == 7'd127) blink_on_d = ~blink_on_q;
        end
      endcase
    end

    if (key_lamp) begin
      case (lamp_en_q)
        2'b11:   lamp_en_d = 2'b01;
        2'b01:   lamp_en_d = 2'b10;
        default: lamp_en_d = 2'b11;
      endcase
    end
    if (key_sync) sync_d = ~sync_q;
  end

  // Duties are computed from the next state so they land in the same edge as the update.
  assign fwd = wheel_rgb(wheel_d, 1'b0);
  assign rev = wheel_rgb(wheel_d, 1'b1);

  always_comb begin
    lamp1 = 24'd0;
    lamp2 = 24'd0;
    unique case (state_d)
      StOff: ;
      StRainbow: begin
        lamp1 = fwd;
        lamp2 = sync_d ? fwd : rev;
      end
      StBreathe: begin
        lamp1 = {3{lvl_d}};
        lamp2 = sync_d ? {3{lvl_d}} : {3{~lvl_d}};
      end
      StBlink: begin
        lamp1 = {24{blink_on_d}};
        lamp2 = sync_d ? {24{blink_on_d}} : {24{~blink_on_d}};
      end
    endcase
    if (!lamp_en_d[0]) lamp1 = 24'd0;
    if (!lamp_en_d[1]) lamp2 = 24'd0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StRainbow;
      div_cnt_q    <= 18'd0;
      limit_q      <= 18'(DIV_DEF);
      wheel_q      <= 10'd0;
      lvl_q        <= 8'd0;
      dir_up_q     <= 1'b1;
      blink_cnt_q  <= 7'd0;
      blink_on_q   <= 1'b1;
      lamp_en_q    <= 2'b11;
      sync_q       <= 1'b1;
      first_q      <= 1'b1;
      lamp1_q      <= 24'd0;
      lamp2_q      <= 24'd0;
      duty_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      div_cnt_q    <= div_cnt_d;
      limit_q      <= limit_d;
      wheel_q      <= wheel_d;
      lvl_q        <= lvl_d;
      dir_up_q     <= dir_up_d;
      blink_cnt_q  <= blink_cnt_d;
      blink_on_q   <= blink_on_d;
      lamp_en_q    <= lamp_en_d;
      sync_q       <= sync_d;
      first_q      <= 1'b0;
      lamp1_q      <= lamp1;
      lamp2_q      <= lamp2;
      duty_valid_q <= upd;
    end
  end

  assign {r1, g1, b1} = lamp1_q;
  assign {r2, g2, b2} = lamp2_q;
  assign duty_valid   = duty_valid_q;
  assign mode         = state_q;

endmodule

// File: tb/tb_rgb_effect_sequencer.sv
// Bench for rgb_effect_sequencer: directed stimulus, an integer-level model of the
// effect rules checked against every output on every cycle, and literal spot checks.
module tb_rgb_effect_sequencer;

  localparam int unsigned TB_F1  = 5;
  localparam int unsigned TB_F2  = 1;
  localparam int unsigned TB_F3  = 2;
  localparam int unsigned TB_F4  = 0;
  localparam int unsigned TB_DEF = 3;

  logic       clk = 1'b0;
  logic       rst, key_mode, key_lamp, key_sync;
  logic [3:0] sw;
  logic [7:0] r1, g1, b1, r2, g2, b2;
  logic       duty_valid;
  logic [1:0] mode;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  rgb_effect_sequencer #(
    .DIV_F1 (TB_F1),
    .DIV_F2 (TB_F2),
    .DIV_F3 (TB_F3),
    .DIV_F4 (TB_F4),
    .DIV_DEF(TB_DEF)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .key_mode  (key_mode),
    .key_lamp  (key_lamp),
    .key_sync  (key_sync),
    .sw        (sw),
    .r1        (r1),
    .g1        (g1),
    .b1        (b1),
    .r2        (r2),
    .g2        (g2),
    .b2        (b2),
    .duty_valid(duty_valid),
    .mode      (mode)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model state, plain integers.
  int m_mode, m_wheel, m_lvl, m_bcnt, m_en, m_cnt, m_lim;
  bit m_up, m_bon, m_sync, m_first;
  int e_r1, e_g1, e_b1, e_r2, e_g2, e_b2;
  bit e_dv;

  function automatic int lim_of(input logic [3:0] s);
    if (s == 4'b1000) return TB_F1;
    if (s == 4'b0100) return TB_F2;
    if (s == 4'b0010) return TB_F3;
    if (s == 4'b0001) return TB_F4;
    return TB_DEF;
  endfunction

  // Colour wheel written straight from the range tables.
  task automatic wheel_col(input int p, input bit rv, output int r, output int g, output int b);
    if (p < 255) begin
      r = 255 - p;
      g = rv ? p : 0;
      b = rv ? 0 : p;
    end else if (p < 510) begin
      r = 0;
      g = rv ? 510 - p : p - 255;
      b = rv ? p - 255 : 510 - p;
    end else begin
      r = p - 510;
      g = rv ? 0 : 765 - p;
      b = rv ? 765 - p : 0;
    end
  endtask

  task automatic model_duty();
    int v;
    e_r1 = 0; e_g1 = 0; e_b1 = 0; e_r2 = 0; e_g2 = 0; e_b2 = 0;
    if (m_mode == 1) begin
      wheel_col(m_wheel, 1'b0, e_r1, e_g1, e_b1);
      wheel_col(m_wheel, !m_sync, e_r2, e_g2, e_b2);
    end else if (m_mode == 2 || m_mode == 3) begin
      v = (m_mode == 2) ? m_lvl : (m_bon ? 255 : 0);
      e_r1 = v; e_g1 = v; e_b1 = v;
      v = m_sync ? v : 255 - v;
      e_r2 = v; e_g2 = v; e_b2 = v;
    end
    if ((m_en & 1) == 0) begin e_r1 = 0; e_g1 = 0; e_b1 = 0; end
    if ((m_en & 2) == 0) begin e_r2 = 0; e_g2 = 0; e_b2 = 0; end
  endtask

  always @(posedge clk) begin
    bit tk;
    if (rst) begin
      m_mode = 1; m_wheel = 0; m_lvl = 0; m_up = 1; m_bcnt = 0; m_bon = 1;
      m_en = 3; m_sync = 1; m_cnt = 0; m_lim = TB_DEF; m_first = 1;
      e_r1 = 0; e_g1 = 0; e_b1 = 0; e_r2 = 0; e_g2 = 0; e_b2 = 0; e_dv = 0;
    end else begin
      tk = (m_cnt == m_lim);
      e_dv = m_first || tk || key_mode || key_lamp || key_sync;
      m_first = 0;
      if (tk) begin
        m_cnt = 0;
        m_lim = lim_of(sw);
      end else begin
        m_cnt++;
      end
      if (key_mode) begin
        m_mode = (m_mode + 1) % 4;
        m_wheel = 0; m_lvl = 0; m_up = 1; m_bcnt = 0; m_bon = 1;
      end else if (tk) begin
        if (m_mode == 1) m_wheel = (m_wheel + 1) % 765;
        else if (m_mode == 2) begin
          if (m_up && m_lvl == 255) m_up = 0;
          else if (!m_up && m_lvl == 0) m_up = 1;
          m_lvl = m_up ? m_lvl + 1 : m_lvl - 1;
        end else if (m_mode == 3) begin
          m_bcnt = (m_bcnt + 1) % 128;
          if (m_bcnt == 0) m_bon = !m_bon;
        end
      end
      if (key_lamp) m_en = (m_en == 3) ? 1 : (m_en == 1) ? 2 : 3;
      if (key_sync) m_sync = !m_sync;
      model_duty();
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("r1", r1, e_r1);
      chk("g1", g1, e_g1);
      chk("b1", b1, e_b1);
      chk("r2", r2, e_r2);
      chk("g2", g2, e_g2);
      chk("b2", b2, e_b2);
      chk("duty_valid", duty_valid, e_dv);
      chk("mode", mode, m_mode);
    end
  end

  // All stimulus tasks are entered and left on a falling edge.
  task automatic wait_model(input bit use_lvl, input int target, input string name);
    int n = 0;
    int v;
    do begin
      @(negedge clk);
      n++;
      v = use_lvl ? m_lvl : m_wheel;
    end while (v != target && n < 2000);
    if (v != target) chk({name, "_timeout"}, v, target);
  endtask

  task automatic wait_dv(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!duty_valid && n < 50);
  endtask

  task automatic pulse(input bit km, input bit kl, input bit ks);
    key_mode = km; key_lamp = kl; key_sync = ks;
    @(negedge clk);
    key_mode = 0; key_lamp = 0; key_sync = 0;
  endtask

  initial begin
    int n;
    rst = 1; key_mode = 0; key_lamp = 0; key_sync = 0; sw = 4'b0000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_en = 1;
    chk("rst_r1", r1, 0);
    chk("rst_dv", duty_valid, 0);
    chk("rst_mode", mode, 1);
    rst = 0;

    // First update after reset, then the first tick four cycles later.
    @(negedge clk);
    chk("first_r1", r1, 255);
    chk("first_g1", g1, 0);
    chk("first_b1", b1, 0);
    chk("first_dv", duty_valid, 1);
    repeat (3) @(negedge clk);
    chk("tick1_r1", r1, 254);
    chk("tick1_b1", b1, 1);
    chk("tick1_dv", duty_valid, 1);

    // Fast ticks, rainbow wrap.
    sw = 4'b0001;
    wait_model(0, 510, "w510");
    chk("w510_r1", r1, 0);
    chk("w510_g1", g1, 255);
    chk("w510_b1", b1, 0);
    wait_model(0, 764, "w764");
    chk("w764_r1", r1, 254);
    chk("w764_g1", g1, 1);
    wait_model(0, 0, "wrap");
    chk("wrap_r1", r1, 255);
    chk("wrap_g1", g1, 0);
    chk("wrap_b1", b1, 0);

    // Reverse colour on lamp 2.
    pulse(0, 0, 1);
    wait_model(0, 300, "w300");
    chk("w300_g1", g1, 45);
    chk("w300_b1", b1, 210);
    chk("w300_r2", r2, 0);
    chk("w300_g2", g2, 210);
    chk("w300_b2", b2, 45);

    // Breathe turn-around with sync off.
    pulse(1, 0, 0);
    chk("breathe_mode", mode, 2);
    wait_model(1, 255, "l255");
    chk("l255_r1", r1, 255);
    chk("l255_r2", r2, 0);
    wait_model(1, 254, "l254");
    chk("l254_r1", r1, 254);
    chk("l254_r2", r2, 1);

    // key_mode on a tick cycle (every cycle ticks here): phase restarts without advancing.
    pulse(1, 0, 0);
    pulse(1, 0, 0);
    pulse(1, 0, 0);
    chk("prec_mode", mode, 1);
    chk("prec_r1", r1, 255);
    chk("prec_b1", b1, 0);
    pulse(0, 1, 0);
    chk("gate_r1", r1, 254);
    chk("gate_b1", b1, 1);
    chk("gate_r2", r2, 0);
    chk("gate_g2", g2, 0);
    chk("gate_b2", b2, 0);
    repeat (5) @(negedge clk);
    chk("gate_run_r1", r1, 249);

    // All three keys together.
    pulse(1, 1, 1);
    chk("all3_mode", mode, 2);

    // Speed switch mid-period.
    sw = 4'b0000;
    wait_dv(n);
    wait_dv(n);
    chk("period_def", n, TB_DEF + 1);
    @(negedge clk);
    sw = 4'b1000;
    wait_dv(n);
    chk("period_old", n + 1, TB_DEF + 1);
    wait_dv(n);
    chk("period_f1", n, TB_F1 + 1);

    // Blink, long enough to see blink_on toggle, then reset mid-blink.
    pulse(1, 0, 0);
    chk("blink_mode", mode, 3);
    sw = 4'b0001;
    repeat (300) @(negedge clk);
    rst = 1;
    @(negedge clk);
    chk("mid_rst_mode", mode, 1);
    chk("mid_rst_r1", r1, 0);
    chk("mid_rst_r2", r2, 0);
    chk("mid_rst_dv", duty_valid, 0);
    rst = 0;
    @(negedge clk);
    chk("post_rst_r1", r1, 255);
    chk("post_rst_r2", r2, 255);
    chk("post_rst_dv", duty_valid, 1);
    repeat (20) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
